spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with a two-cycle CPU register port (rxdata, txdata, status, control).
// Optional feature macro SPI_SLAVE_IRQ_EN adds the interrupt-enable control register and a live irq.
module spi_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        irq,
    output logic [1:0]  fsm_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_e;

    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       ss_meta_q, ss_sync_q, ss_prev_q;
    logic       mosi_meta_q, mosi_sync_q;
    logic [1:0] live_q;
    logic       armed_q;
    logic       sclk_rise, sclk_fall, ss_fall;

    // armed_q blocks a bogus SS_n "falling edge" right after reset while SS_n is
    // already low: the slave must first see a real synchronized high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            live_q      <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ss_meta_q   <= SS_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
            live_q      <= {live_q[0], 1'b1};
            armed_q     <= armed_q | (live_q[1] & ss_sync_q);
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign ss_fall   = armed_q & ~ss_sync_q & ss_prev_q;

    // CPU strobes fire once per access on the rising edge of the qualified request.
    logic        rd_lvl, wr_lvl, rd_start, wr_start;
    logic        rd_lvl_q, wr_lvl_q, rd_stb_q, wr_stb_q;
    logic [2:0]  cpu_addr_q;
    logic [15:0] cpu_wdata_q;

    assign rd_lvl   = spi_select & ~read_n;
    assign wr_lvl   = spi_select & ~write_n;
    assign rd_start = rd_lvl & ~rd_lvl_q;
    assign wr_start = wr_lvl & ~wr_lvl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_lvl_q    <= 1'b0;
            wr_lvl_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            cpu_addr_q  <= 3'd0;
            cpu_wdata_q <= 16'h0000;
        end else begin
            rd_lvl_q <= rd_lvl;
            wr_lvl_q <= wr_lvl;
            rd_stb_q <= rd_start;
            wr_stb_q <= wr_start;
            if (rd_start || wr_start) cpu_addr_q <= mem_addr;
            if (wr_start) cpu_wdata_q <= data_from_cpu;
        end
    end

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [7:0]  rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
    logic        primed_q, primed_d;
    logic        rrdy_q, rrdy_d, trdy_q, trdy_d;
    logic        roe_q, roe_d, toe_q, toe_d;
    logic [15:0] dout_q, dout_d;
    logic        byte_done, load_takes;
    logic        err, tmt;
    logic [15:0] status, ctrl_rd;

    assign err    = roe_q | toe_q;
    assign tmt    = ~primed_q & (state_q == IDLE);
    assign status = {5'b0, err, rrdy_q, trdy_q, tmt, toe_q, roe_q, 5'b0};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_hold_d  = rx_hold_q;
        tx_hold_d  = tx_hold_q;
        primed_d   = primed_q;
        rrdy_d     = rrdy_q;
        trdy_d     = trdy_q;
        roe_d      = roe_q;
        toe_d      = toe_q;
        dout_d     = dout_q;
        byte_done  = 1'b0;
        load_takes = 1'b0;

        if (ss_sync_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (ss_fall) state_d = LOAD;
                LOAD: begin
                    tx_shift_d = primed_q ? tx_hold_q : 8'h00;
                    if (primed_q) begin
                        load_takes = 1'b1;
                        primed_d   = 1'b0;
                        trdy_d     = 1'b1;
                    end
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done = 1'b1;
                            rx_hold_d = rx_shift_d;
                            state_d   = LOAD;
                        end
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (rd_stb_q) begin
            case (cpu_addr_q)
                3'd0: begin
                    dout_d = {8'h00, rx_hold_q};
                    rrdy_d = 1'b0;
                end
                3'd2:    dout_d = status;
                3'd3:    dout_d = ctrl_rd;
                default: dout_d = 16'h0000;
            endcase
        end

        if (wr_stb_q) begin
            case (cpu_addr_q)
                3'd1: begin
                    // A holding byte taken by LOAD this same cycle is not an overrun.
                    if (!trdy_q && !load_takes) toe_d = 1'b1;
                    tx_hold_d = cpu_wdata_q[7:0];
                    primed_d  = 1'b1;
                    trdy_d    = 1'b0;
                end
                3'd2: begin
                    roe_d = 1'b0;
                    toe_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Placed last so a completing byte wins over a same-cycle rxdata read or status clear.
        if (byte_done) begin
            if (rrdy_q) roe_d = 1'b1;
            rrdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_hold_q  <= 8'h00;
            tx_hold_q  <= 8'h00;
            primed_q   <= 1'b0;
            rrdy_q     <= 1'b0;
            trdy_q     <= 1'b1;
            roe_q      <= 1'b0;
            toe_q      <= 1'b0;
            dout_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_hold_q  <= rx_hold_d;
            tx_hold_q  <= tx_hold_d;
            primed_q   <= primed_d;
            rrdy_q     <= rrdy_d;
            trdy_q     <= trdy_d;
            roe_q      <= roe_d;
            toe_q      <= toe_d;
            dout_q     <= dout_d;
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    localparam logic [15:0] CTRL_MASK = 16'h01D8;
    logic [15:0] ctrl_q, ctrl_d, irq_src;
    logic        irq_q, irq_d;

    // Enable bits line up with the control register layout: iE[8] iRRDY[7] iTRDY[6] iTOE[4] iROE[3].
    assign irq_src = {7'b0, err, rrdy_q, trdy_q, 1'b0, toe_q, roe_q, 3'b0};

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_stb_q && cpu_addr_q == 3'd3) ctrl_d = cpu_wdata_q & CTRL_MASK;
        irq_d = |(ctrl_q & irq_src);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 16'h0000;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_rd = ctrl_q;
    assign irq     = irq_q;
`else
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^cpu_wdata_q[15:8];
    assign ctrl_rd         = 16'h0000;
    assign irq             = 1'b0;
`endif

    assign MISO          = tx_shift_q[7];
    assign MISO_oe       = ~ss_sync_q;
    assign data_to_cpu   = dout_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = trdy_q;
    assign fsm_state_o   = state_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI mode-0 master and CPU-port driver for spi_slave, checked against
// a register-level model of the slave; honours SPI_SLAVE_IRQ_EN when defined.
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        SCLK, SS_n, MOSI;
    logic        MISO, MISO_oe;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        dataavailable, readyfordata, irq;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;
    int cmp_prints = 0;
    bit chk_en = 1'b0;

    spi_slave dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe),
        .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
        .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .dataavailable(dataavailable), .readyfordata(readyfordata), .irq(irq),
        .fsm_state_o(fsm_state)
    );

    always #5 clk = ~clk;

    // Register-level model of the slave as seen by the CPU and the master.
    logic       m_rrdy, m_trdy, m_roe, m_toe, m_primed, m_in_frame;
    logic [7:0] m_txh, m_rxh, m_cur_tx;
    logic [15:0] m_ctrl;

    task automatic m_reset();
        m_rrdy = 0; m_trdy = 1; m_roe = 0; m_toe = 0; m_primed = 0;
        m_txh = 0; m_rxh = 0; m_cur_tx = 0; m_ctrl = 0;
    endtask

    task automatic m_load();
        m_cur_tx = m_primed ? m_txh : 8'h00;
        if (m_primed) begin
            m_primed = 0;
            m_trdy   = 1;
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'h0000;
        s[10] = m_roe | m_toe;
        s[9]  = m_rrdy;
        s[8]  = m_trdy;
        s[7]  = ~m_primed & ~m_in_frame;
        s[6]  = m_toe;
        s[5]  = m_roe;
        return s;
    endfunction

    function automatic logic m_irq();
`ifdef SPI_SLAVE_IRQ_EN
        return (m_ctrl[8] & (m_roe | m_toe)) | (m_ctrl[7] & m_rrdy) | (m_ctrl[6] & m_trdy) |
               (m_ctrl[4] & m_toe) | (m_ctrl[3] & m_roe);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {8'h00, m_rxh};
            3'd2:    return m_status();
`ifdef SPI_SLAVE_IRQ_EN
            3'd3:    return m_ctrl;
`endif
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Continuous comparison of the status flags whenever the bench is between transactions.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({dataavailable, readyfordata, irq, MISO_oe} !== {m_rrdy, m_trdy, m_irq(), 1'b0}) begin
                failures++;
                if (cmp_prints < 10) begin
                    cmp_prints++;
                    $display("FAIL cmp_flags t=%0t got rrdy,trdy,irq,oe=%b%b%b%b exp=%b%b%b0", $time,
                             dataavailable, readyfordata, irq, MISO_oe, m_rrdy, m_trdy, m_irq());
                end
            end
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        chk_en = 0;
        spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        spi_select = 0; write_n = 1;
        repeat (3) @(negedge clk);
        case (a)
            3'd1: begin
                if (!m_trdy) m_toe = 1;
                m_txh = d[7:0]; m_primed = 1; m_trdy = 0;
            end
            3'd2: begin m_roe = 0; m_toe = 0; end
`ifdef SPI_SLAVE_IRQ_EN
            3'd3: m_ctrl = d & 16'h01D8;
`endif
            default: ;
        endcase
        chk_en = 1;
    endtask

    task automatic cpu_read(input logic [2:0] a, input string name, output logic [15:0] got);
        logic [15:0] exp;
        chk_en = 0;
        exp = m_read(a);
        spi_select = 1; read_n = 0; mem_addr = a;
        @(negedge clk);
        spi_select = 0; read_n = 1;
        repeat (3) @(negedge clk);
        got = data_to_cpu;
        check(name, got, exp);
        if (a == 3'd0) m_rrdy = 0;
        chk_en = 1;
    endtask

    task automatic spi_begin();
        chk_en = 0;
        SS_n = 0;
        m_in_frame = 1;
        m_load();
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (3) @(negedge clk);
        SS_n = 1;
        repeat (6) @(negedge clk);
        m_in_frame = 0;
        chk_en = 1;
    endtask

    // Mode 0: MOSI changes while SCLK is low, both sides sample on the rising edge.
    task automatic spi_byte(input logic [7:0] mo, input int nrise, output logic [7:0] got);
        logic [7:0] exp_tx;
        exp_tx = m_cur_tx;
        got = 8'h00;
        for (int i = 0; i < nrise; i++) begin
            MOSI = mo[7-i];
            repeat (5) @(negedge clk);
            SCLK = 1;
            got[7-i] = MISO;
            check("miso_oe", {15'b0, MISO_oe}, 16'h0001);
            repeat (5) @(negedge clk);
            SCLK = 0;
        end
        if (nrise == 8) begin
            check("miso_byte", {8'h00, got}, {8'h00, exp_tx});
            if (m_rrdy) m_roe = 1;
            m_rrdy = 1;
            m_rxh  = mo;
            m_load();
        end
    endtask

    logic [15:0] rd;
    logic [7:0]  got_a, got_b;
    int          wait_n;

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1; SCLK = 0; SS_n = 1; MOSI = 0;
        spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
        m_reset(); m_in_frame = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        chk_en = 1;

        // Reset state
        check("rst_rrdy", {15'b0, dataavailable}, 16'h0000);
        check("rst_trdy", {15'b0, readyfordata}, 16'h0001);
        check("rst_miso", {14'b0, MISO, MISO_oe}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_dout", data_to_cpu, 16'h0000);
        cpu_read(3'd2, "rst_status", rd);
        check("rst_status_lit", rd, 16'h0180);

        // Primed transmit of A5 while receiving 3C
        cpu_write(3'd1, 16'h00A5);
        cpu_read(3'd2, "primed_status", rd);
        check("primed_status_lit", rd, 16'h0000);
        spi_begin();
        spi_byte(8'h3C, 8, got_a);
        spi_end();
        check("tx_a5_lit", {8'h00, got_a}, 16'h00A5);
        check("rrdy_set", {15'b0, dataavailable}, 16'h0001);
        cpu_read(3'd0, "rx_3c", rd);
        check("rx_3c_lit", rd, 16'h003C);
        check("rrdy_cleared", {15'b0, dataavailable}, 16'h0000);

        // Back-to-back bytes with nothing primed: overrun
        spi_begin();
        spi_byte(8'h11, 8, got_a);
        spi_byte(8'h22, 8, got_b);
        spi_end();
        check("tx_zero_lit", {got_a, got_b}, 16'h0000);
        cpu_read(3'd2, "roe_status", rd);
        check("roe_status_lit", rd, 16'h07A0);
        cpu_read(3'd0, "rx_22", rd);
        check("rx_22_lit", rd, 16'h0022);
        cpu_write(3'd2, 16'hFFFF);
        cpu_read(3'd2, "cleared_status", rd);
        check("cleared_status_lit", rd, 16'h0180);

        // Double txdata write: TOE, newest byte sent
        cpu_write(3'd1, 16'h0001);
        cpu_write(3'd1, 16'h0002);
        cpu_read(3'd2, "toe_status", rd);
        check("toe_status_lit", rd, 16'h0440);
        spi_begin();
        spi_byte(8'h77, 8, got_a);
        spi_end();
        check("tx_02_lit", {8'h00, got_a}, 16'h0002);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd0, "rx_77", rd);

        // Partial byte aborted by SS_n, then a clean byte
        spi_begin();
        spi_byte(8'hFF, 5, got_a);
        spi_end();
        check("abort_rrdy", {15'b0, dataavailable}, 16'h0000);
        cpu_read(3'd0, "abort_rx_hold", rd);
        check("abort_rx_hold_lit", rd, 16'h0077);
        spi_begin();
        spi_byte(8'h5A, 8, got_a);
        spi_end();
        cpu_read(3'd0, "rx_5a", rd);
        check("rx_5a_lit", rd, 16'h005A);

        // Unmapped and write-only addresses
        cpu_read(3'd1, "rd_txdata", rd);
        cpu_read(3'd5, "rd_unmapped", rd);
        check("rd_unmapped_lit", rd, 16'h0000);

        // Reset in the middle of a byte
        spi_begin();
        spi_byte(8'hC3, 4, got_a);
        reset = 1;
        @(negedge clk);
        check("mid_rst_miso", {14'b0, MISO, MISO_oe}, 16'h0000);
        check("mid_rst_dout", data_to_cpu, 16'h0000);
        check("mid_rst_flags", {13'b0, dataavailable, readyfordata, irq}, 16'h0002);
        reset = 0;
        m_reset();
        spi_end();
        spi_begin();
        spi_byte(8'hC3, 8, got_a);
        spi_end();
        cpu_read(3'd0, "rx_c3", rd);
        check("rx_c3_lit", rd, 16'h00C3);

        // Interrupt on RRDY
        cpu_write(3'd3, 16'h0080);
        cpu_read(3'd3, "ctrl_rd", rd);
        spi_begin();
        fork
            spi_byte(8'h96, 8, got_a);
            begin
                wait_n = 0;
                while (dataavailable !== 1'b1 && wait_n < 200) begin
                    @(negedge clk);
                    wait_n++;
                end
                check("irq_wait_rrdy", {15'b0, dataavailable}, 16'h0001);
                check("irq_same_cycle", {15'b0, irq}, 16'h0000);
                @(negedge clk);
`ifdef SPI_SLAVE_IRQ_EN
                check("irq_next_cycle", {15'b0, irq}, 16'h0001);
`else
                check("irq_next_cycle", {15'b0, irq}, 16'h0000);
`endif
            end
        join
        spi_end();
        cpu_read(3'd0, "rx_96", rd);
        check("rx_96_lit", rd, 16'h0096);
        check("irq_after_read", {15'b0, irq}, 16'h0000);

        repeat (5) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
